// File: rtl/toggle_event_decoder_pkg.sv
// Shared types for the toggle event decoder: the per-edge counter operation.
// Optional overflow clear is enabled by TOGGLE_EVENT_DECODER_OVERFLOW_CLEAR_EN.
package toggle_event_decoder_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_SAT  = 2'd3
  } count_op_e;

  // An increment that meets an accept cancels out, even at the maximum count.
  function automatic count_op_e count_op(input logic inc, input logic dec, input logic at_max);
    count_op_e op;
    op = CNT_HOLD;
    if (inc && !dec) begin
      op = at_max ? CNT_SAT : CNT_INC;
    end else if (dec && !inc) begin
      op = CNT_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/toggle_event_decoder_edge_detector.sv
// Samples the toggle level through SYNC_STAGES flops and emits a registered
// one-cycle pulse for every level transition seen at the end of the chain.
module toggle_edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic toggle,
  output logic detect,
  output logic event_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_level;

  assign detect = sync_q[SYNC_STAGES-1] ^ prev_level;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '0;
      prev_level  <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      sync_q[0] <= toggle;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_level  <= sync_q[SYNC_STAGES-1];
      event_pulse <= detect;
    end
  end

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event receiver: edge detector plus a saturating pending-event
// counter drained by valid/ready. TOGGLE_EVENT_DECODER_OVERFLOW_CLEAR_EN adds overflow_clear.
module toggle_event_decoder
  import toggle_event_decoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     toggle,
`ifdef TOGGLE_EVENT_DECODER_OVERFLOW_CLEAR_EN
  input  logic                     overflow_clear,
`endif
  output logic                     event_pulse,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [COUNTER_WIDTH-1:0] pending_count,
  output logic                     overflow
);

  logic      detect;
  logic      accept;
  logic      at_max;
  logic      overflow_set;
  count_op_e op;

  toggle_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clock      (clock),
    .resetn     (resetn),
    .toggle     (toggle),
    .detect     (detect),
    .event_pulse(event_pulse)
  );

  // Valid decodes only the count register, so ready never feeds back into it.
  assign event_valid  = (pending_count != '0);
  assign accept       = event_valid && event_ready;
  assign at_max       = (pending_count == {COUNTER_WIDTH{1'b1}});
  assign overflow_set = (op == CNT_SAT);

  always_comb begin
    op = CNT_HOLD;
    op = count_op(detect, accept, at_max);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_count <= '0;
    end else begin
      case (op)
        CNT_INC: pending_count <= pending_count + COUNTER_WIDTH'(1);
        CNT_DEC: pending_count <= pending_count - COUNTER_WIDTH'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

  // A saturating increment wins over a clear in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else begin
`ifdef TOGGLE_EVENT_DECODER_OVERFLOW_CLEAR_EN
      overflow <= overflow_set | (overflow & ~overflow_clear);
`else
      overflow <= overflow_set | overflow;
`endif
    end
  end

endmodule
